// File: rtl/serial_addsub_framed.sv
// Digit-serial two's-complement adder/subtractor with registered outputs, LS digit first,
// framed words with per-word add/sub mode, end-of-word flags and framing-error pulses.
module serial_addsub_framed #(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               carry_out,
  output logic               overflow,
  output logic               frame_err
);

  localparam int unsigned CntW = (WORD_DIGITS > 2) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(WORD_DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
  logic               out_last_q, out_last_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               frame_err_q, frame_err_d;

  logic               accept;
  logic               sub_eff;
  logic               cin;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   sum_full;
  logic               c_msb_in;

  always_comb begin
    accept   = in_valid && ((state_q == StRun) || in_first);
    // A first digit always starts a fresh word, even when it aborts one in progress.
    sub_eff  = in_first ? sub : mode_q;
    cin      = in_first ? sub : carry_q;
    b_eff    = sub_eff ? ~b : b;
    sum_full = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
    // Carry into the digit MSB recovered from the sum bit and the two operand bits.
    c_msb_in = sum_full[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    out_valid_d = 1'b0;
    out_sum_d   = out_sum_q;
    out_last_d  = 1'b0;
    carry_out_d = 1'b0;
    overflow_d  = 1'b0;
    frame_err_d = 1'b0;

    if (in_valid) begin
      if (state_q == StIdle && !in_first) begin
        frame_err_d = 1'b1;
      end else if (state_q == StRun && in_first) begin
        frame_err_d = 1'b1;
      end
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = sum_full[DIGIT_W-1:0];
      carry_d     = sum_full[DIGIT_W];
      if (in_first) begin
        mode_d  = sub;
        state_d = StRun;
        cnt_d   = CntW'(1);
      end else if (cnt_q == LastIdx) begin
        state_d     = StIdle;
        cnt_d       = '0;
        out_last_d  = 1'b1;
        carry_out_d = sum_full[DIGIT_W];
        overflow_d  = c_msb_in ^ sum_full[DIGIT_W];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
